// File: rtl/fillrect_pkg.sv
// Shared types and defaults for the rectangle filler.
package fill_pkg;
    typedef enum logic [1:0] {READY, DRAW, DONE} state_t;
    typedef enum logic [1:0] {SOLID, VSTRIPE, HSTRIPE, CHECKER} mode_t;

    localparam int DEF_SCREEN_W = 160;
    localparam int DEF_SCREEN_H = 120;
endpackage

// File: rtl/fillrect_raster_scan.sv
// Column-major x/y scanner over a rectangle clipped to the screen bounds.
module raster_scan #(
    parameter int XW       = 8,
    parameter int YW       = 7,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          step,
    input  logic [XW-1:0] x0,
    input  logic [YW-1:0] y0,
    input  logic [XW-1:0] x1,
    input  logic [YW-1:0] y1,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          last,
    output logic          empty
);
    localparam logic [XW-1:0] X_MAX = XW'(SCREEN_W - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(SCREEN_H - 1);

    logic [XW-1:0] x1_clip, x1c_q;
    logic [YW-1:0] y1_clip, y1c_q, y0_q;

    assign x1_clip = (x1 > X_MAX) ? X_MAX : x1;
    assign y1_clip = (y1 > Y_MAX) ? Y_MAX : y1;
    assign empty   = (x0 > x1_clip) || (y0 > y1_clip);
    assign last    = (x == x1c_q) && (y == y1c_q);

    // Bounds are tested before stepping, so x never advances past x1c_q
    // and therefore can never wrap at the right screen edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x     <= '0;
            y     <= '0;
            y0_q  <= '0;
            x1c_q <= '0;
            y1c_q <= '0;
        end else if (load) begin
            x     <= x0;
            y     <= y0;
            y0_q  <= y0;
            x1c_q <= x1_clip;
            y1c_q <= y1_clip;
        end else if (step) begin
            if (y == y1c_q) begin
                y <= y0_q;
                x <= x + 1'b1;
            end else begin
                y <= y + 1'b1;
            end
        end
    end
endmodule

// File: rtl/fillrect.sv
// Clipped rectangle filler: start/done handshake, one pixel per clock, four colour modes.
module fillrect
    import fill_pkg::*;
#(
    parameter int SCREEN_W  = DEF_SCREEN_W,
    parameter int SCREEN_H  = DEF_SCREEN_H,
    parameter int XW        = 8,
    parameter int YW        = 7,
    parameter int CW        = 3,
    parameter int CHK_SHIFT = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [1:0]    mode,
    input  logic [CW-1:0] colour,
    input  logic [XW-1:0] x0,
    input  logic [YW-1:0] y0,
    input  logic [XW-1:0] x1,
    input  logic [YW-1:0] y1,
    output logic          done,
    output logic          busy,
    output logic [XW-1:0] vga_x,
    output logic [YW-1:0] vga_y,
    output logic [CW-1:0] vga_colour,
    output logic          vga_plot
);
    state_t        state, state_nxt;
    mode_t         mode_q;
    logic [CW-1:0] colour_q;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          load, step, last, empty;

    assign load = (state == READY) && start;
    assign step = (state == DRAW) && !last;

    raster_scan #(
        .XW(XW), .YW(YW), .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H)
    ) u_scan (
        .clk(clk), .rst_n(rst_n), .load(load), .step(step),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1),
        .x(x), .y(y), .last(last), .empty(empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= READY;
            mode_q   <= SOLID;
            colour_q <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                mode_q   <= mode_t'(mode);
                colour_q <= colour;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        busy      = 1'b0;
        vga_plot  = 1'b0;
        case (state)
            READY: if (start) state_nxt = empty ? DONE : DRAW;
            DRAW: begin
                busy     = 1'b1;
                vga_plot = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (!start) state_nxt = READY;
            end
            default: state_nxt = READY;
        endcase
    end

    // Pixel position comes straight from the counters, which hold after the last plot.
    assign vga_x = x;
    assign vga_y = y;

    always_comb begin
        vga_colour = colour_q;
        case (mode_q)
            SOLID:   vga_colour = colour_q;
            VSTRIPE: vga_colour = x[CW-1:0];
            HSTRIPE: vga_colour = y[CW-1:0];
            CHECKER: vga_colour = (x[CHK_SHIFT] ^ y[CHK_SHIFT]) ? ~colour_q : colour_q;
            default: vga_colour = colour_q;
        endcase
    end
endmodule

// File: tb/tb_fillrect.sv
// Scoreboard bench for fillrect: model pushes expected plots, a monitor pops and compares.
module tb_fillrect;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] mode = '0;
    logic [2:0] colour = '0;
    logic [7:0] x0 = '0, x1 = '0;
    logic [6:0] y0 = '0, y1 = '0;
    logic       done, busy, vga_plot;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;

    int tests = 0;
    int fails = 0;

    typedef struct { int x; int y; int c; } pix_t;
    pix_t exp_q[$];

    fillrect dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .colour(colour),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1),
        .done(done), .busy(busy), .vga_x(vga_x), .vga_y(vga_y),
        .vga_colour(vga_colour), .vga_plot(vga_plot)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Reference pixel colour from the mode rules.
    function automatic int ref_colour(int m, int c, int px, int py);
        case (m)
            0: return c;
            1: return px % 8;
            2: return py % 8;
            default: return ((((px / 8) + (py / 8)) % 2) == 1) ? (7 - c) : c;
        endcase
    endfunction

    // Push the expected plot sequence; returns the plot count.
    function automatic int model(int m, int c, int ax0, int ay0, int ax1, int ay1);
        int xc, yc, n;
        xc = (ax1 > 159) ? 159 : ax1;
        yc = (ay1 > 119) ? 119 : ay1;
        n = 0;
        for (int px = ax0; px <= xc; px++)
            for (int py = ay0; py <= yc; py++) begin
                pix_t p;
                p.x = px; p.y = py; p.c = ref_colour(m, c, px, py);
                exp_q.push_back(p);
                n++;
            end
        return n;
    endfunction

    always @(negedge clk) begin
        if (rst_n && vga_plot) begin
            if (exp_q.size() == 0) begin
                check("unexpected_plot", {vga_x, vga_y}, 32'hFFFF_FFFF);
            end else begin
                pix_t e;
                e = exp_q.pop_front();
                tests++;
                if (vga_x !== 8'(e.x) || vga_y !== 7'(e.y) || vga_colour !== 3'(e.c)) begin
                    fails++;
                    $display("FAIL plot: got (%0d,%0d,c%0d) expected (%0d,%0d,c%0d)",
                             vga_x, vga_y, vga_colour, e.x, e.y, e.c);
                end
            end
        end
    end

    task automatic run_rect(input int m, input int c, input int ax0, input int ay0,
                            input int ax1, input int ay1, input bit disturb);
        int n, cyc;
        @(posedge clk); #1;
        mode = 2'(m); colour = 3'(c);
        x0 = 8'(ax0); y0 = 7'(ay0); x1 = 8'(ax1); y1 = 7'(ay1);
        start = 1'b1;
        n = model(m, c, ax0, ay0, ax1, ay1);
        @(posedge clk);
        cyc = 0;
        while (1) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1 && n > 0) begin
                check("first_cycle_plot", vga_plot, 1'b1);
                check("first_cycle_busy", busy, 1'b1);
            end
            if (disturb && cyc == 3) begin
                start = 1'b0; colour = ~colour; mode = mode + 2'd1; x0 = x0 + 8'd7;
            end
            if (done) break;
            if (cyc > 20000) begin
                check("done_timeout", cyc, n + 1);
                break;
            end
        end
        check("done_cycle", cyc, n + 1);
        check("plot_at_done", vga_plot, 1'b0);
        check("queue_drained", exp_q.size(), 0);
        exp_q.delete();
        start = 1'b0;
        @(negedge clk);
        check("done_clears", done, 1'b0);
        check("idle_no_plot", vga_plot, 1'b0);
    endtask

    initial begin
        #12;
        check("rst_done", done, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_plot", vga_plot, 1'b0);
        check("rst_pixel", {vga_x, vga_y, vga_colour}, 0);
        @(negedge clk); rst_n = 1'b1;

        run_rect(0, 4, 0, 0, 159, 119, 0);      // full screen
        run_rect(1, 5, 10, 20, 12, 21, 0);      // small VSTRIPE
        run_rect(0, 6, 150, 110, 255, 127, 0);  // clipped
        run_rect(0, 1, 5, 0, 3, 10, 0);         // empty
        run_rect(2, 0, 200, 0, 255, 5, 0);      // fully off-screen
        run_rect(3, 1, 6, 0, 9, 0, 0);          // checker row
        run_rect(2, 3, 40, 0, 40, 119, 0);      // HSTRIPE column
        run_rect(3, 5, 0, 0, 17, 17, 0);
        run_rect(0, 2, 30, 30, 40, 35, 1);      // mid-draw disturbance

        // Asynchronous reset mid-draw.
        @(posedge clk); #1;
        mode = 2'd0; colour = 3'd7; x0 = 8'd0; y0 = 7'd0; x1 = 8'd9; y1 = 7'd9;
        start = 1'b1;
        void'(model(0, 7, 0, 0, 9, 9));
        @(posedge clk);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_plot", vga_plot, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_pixel", {vga_x, vga_y, vga_colour}, 0);
        start = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("arst_hold_plot", vga_plot, 1'b0);
        rst_n = 1'b1;
        run_rect(1, 0, 3, 4, 6, 8, 0);

        for (int i = 0; i < 25; i++) begin
            int ax0, ay0;
            ax0 = $urandom_range(0, 175);
            ay0 = $urandom_range(0, 125);
            run_rect($urandom_range(0, 3), $urandom_range(0, 7), ax0, ay0,
                     (ax0 + $urandom_range(0, 14)) % 256 > ax0 - 3 ? (ax0 + $urandom_range(0, 14)) % 256 : ax0,
                     (ay0 + $urandom_range(0, 12)) % 128,
                     ($urandom_range(0, 3) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
